// File: rtl/machine_trap_unit.sv
// machine_trap_unit: M-mode CSR file with set/clear ops, registered read
// response, interrupt arbitration and the trap-entry / MRET sequencer that
// redirects fetch. The core stalls while busy_o is high.
//
// CSR handshake: a request is accepted in any cycle where csr_valid_i and
// csr_ready_o are both high. The update lands at the end of that cycle, and
// exactly one cycle later csr_read_data_valid_o pulses with the old value
// (or with data 0 and csr_illegal_o set when the access was rejected).
// There is no back-pressure on the response side.
module machine_trap_unit #(
    parameter int unsigned      MXLEN         = 32,
    parameter int unsigned      NUM_LOCAL_IRQ = 4,
    parameter logic [MXLEN-1:0] HART_ID       = '0,
    parameter logic [31:0]      MISA_VALUE    = 32'h4000_1104,
    parameter logic [MXLEN-1:0] MTVEC_RESET   = '0
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       csr_valid_i,
    input  logic [11:0]                csr_address_i,
    input  logic [1:0]                 csr_op_i,
    input  logic [MXLEN-1:0]           csr_write_data_i,
    output logic                       csr_ready_o,
    output logic [MXLEN-1:0]           csr_read_data_o,
    output logic                       csr_read_data_valid_o,
    output logic                       csr_illegal_o,
    input  logic                       exception_i,
    input  logic [4:0]                 exception_cause_i,
    input  logic [MXLEN-1:0]           exception_tval_i,
    input  logic [MXLEN-1:0]           commit_pc_i,
    input  logic                       mret_i,
    input  logic [3+NUM_LOCAL_IRQ-1:0] irq_i,
    output logic                       busy_o,
    output logic                       redirect_o,
    output logic [MXLEN-1:0]           redirect_pc_o,
    output logic [1:0]                 dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_TRAP_SAVE     = 2'd1,
        ST_TRAP_REDIRECT = 2'd2,
        ST_MRET_REDIRECT = 2'd3
    } state_t;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [MXLEN-1:0] LOCAL_MASK =
        MXLEN'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16);
    localparam logic [MXLEN-1:0] MIE_MASK = LOCAL_MASK | MXLEN'(32'h0000_0888);

    state_t           r_state;
    logic             r_mstatus_mie;
    logic             r_mstatus_mpie;
    logic [MXLEN-1:0] r_mie;
    logic [MXLEN-1:0] r_mip;
    logic [MXLEN-1:0] r_mtvec;
    logic [MXLEN-1:0] r_mscratch;
    logic [MXLEN-1:0] r_mepc;
    logic [MXLEN-1:0] r_mcause;
    logic [MXLEN-1:0] r_mtval;
    logic [4:0]       r_trap_code;
    logic             r_trap_irq;
    logic [MXLEN-1:0] r_trap_tval;
    logic [MXLEN-1:0] r_trap_pc;
    logic [MXLEN-1:0] r_rdata;
    logic             r_rvalid;
    logic             r_illegal;
    logic             r_redirect;
    logic [MXLEN-1:0] r_redirect_pc;

    logic             w_idle;
    logic [MXLEN-1:0] w_mip_next;
    logic [MXLEN-1:0] w_pending;
    logic [4:0]       w_irq_code;
    logic             w_take_irq;
    logic             w_accept;
    logic [MXLEN-1:0] w_mstatus;
    logic [MXLEN-1:0] w_old;
    logic             w_impl;
    logic             w_ro;
    logic             w_wants_write;
    logic             w_illegal;
    logic [MXLEN-1:0] w_new;
    logic             w_do_write;
    logic [MXLEN-1:0] w_base;
    logic [MXLEN-1:0] w_trap_target;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_pending   = r_mip & r_mie;
    assign w_take_irq  = w_idle && r_mstatus_mie && (|w_pending) && !exception_i;
    // Ready is held low during reset so nothing is accepted while state clears.
    assign csr_ready_o = w_idle && !reset_i && !exception_i && !w_take_irq && !mret_i;
    assign w_accept    = csr_valid_i && csr_ready_o;

    // Map interrupt lines onto their mip bit positions.
    always_comb begin
        w_mip_next                         = '0;
        w_mip_next[3]                      = irq_i[0];
        w_mip_next[7]                      = irq_i[1];
        w_mip_next[11]                     = irq_i[2];
        w_mip_next[16 +: NUM_LOCAL_IRQ]    = irq_i[3 +: NUM_LOCAL_IRQ];
    end

    // Pick the winning interrupt: later assignments override earlier ones.
    always_comb begin
        w_irq_code = '0;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            if (w_pending[16+i]) w_irq_code = 5'(16 + i);
        end
        if (w_pending[7])  w_irq_code = 5'd7;
        if (w_pending[3])  w_irq_code = 5'd3;
        if (w_pending[11]) w_irq_code = 5'd11;
    end

    // Decode the addressed CSR, its current value and the op's new value.
    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mstatus_mpie;
        w_mstatus[3]     = r_mstatus_mie;
        w_old  = '0;
        w_impl = 1'b1;
        w_ro   = 1'b0;
        case (csr_address_i)
            12'h300: w_old = w_mstatus;
            12'h301: begin w_old = MXLEN'(MISA_VALUE); w_ro = 1'b1; end
            12'h304: w_old = r_mie;
            12'h305: w_old = r_mtvec;
            12'h340: w_old = r_mscratch;
            12'h341: w_old = r_mepc;
            12'h342: w_old = r_mcause;
            12'h343: w_old = r_mtval;
            12'h344: begin w_old = r_mip; w_ro = 1'b1; end
            12'hF14: begin w_old = HART_ID; w_ro = 1'b1; end
            default: w_impl = 1'b0;
        endcase
        // SET/CLEAR with a zero operand are pure reads.
        w_wants_write = (csr_op_i == OP_WRITE) ||
                        (((csr_op_i == OP_SET) || (csr_op_i == OP_CLEAR)) && (|csr_write_data_i));
        w_illegal = !w_impl || (w_ro && w_wants_write);
        case (csr_op_i)
            OP_WRITE: w_new = csr_write_data_i;
            OP_SET:   w_new = w_old | csr_write_data_i;
            OP_CLEAR: w_new = w_old & ~csr_write_data_i;
            default:  w_new = w_old;
        endcase
        w_do_write = w_accept && !w_illegal && w_wants_write;
    end

    assign w_base        = {r_mtvec[MXLEN-1:2], 2'b00};
    assign w_trap_target = ((r_mtvec[1:0] == 2'b01) && r_trap_irq)
                         ? (w_base + (MXLEN'(r_trap_code) << 2)) : w_base;

    // Trap sequencer FSM together with all architectural CSR state it shares.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state        <= ST_IDLE;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RESET;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_trap_code    <= '0;
            r_trap_irq     <= 1'b0;
            r_trap_tval    <= '0;
            r_trap_pc      <= '0;
            r_redirect     <= 1'b0;
            r_redirect_pc  <= '0;
        end else begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (exception_i) begin
                        r_trap_code <= exception_cause_i;
                        r_trap_tval <= exception_tval_i;
                        r_trap_pc   <= commit_pc_i;
                        r_trap_irq  <= 1'b0;
                        r_state     <= ST_TRAP_SAVE;
                    end else if (w_take_irq) begin
                        r_trap_code <= w_irq_code;
                        r_trap_tval <= '0;
                        r_trap_pc   <= commit_pc_i;
                        r_trap_irq  <= 1'b1;
                        r_state     <= ST_TRAP_SAVE;
                    end else if (mret_i) begin
                        r_mstatus_mie  <= r_mstatus_mpie;
                        r_mstatus_mpie <= 1'b1;
                        r_redirect     <= 1'b1;
                        r_redirect_pc  <= r_mepc;
                        r_state        <= ST_MRET_REDIRECT;
                    end else if (w_do_write) begin
                        case (csr_address_i)
                            12'h300: begin
                                r_mstatus_mie  <= w_new[3];
                                r_mstatus_mpie <= w_new[7];
                            end
                            12'h304: r_mie <= w_new & MIE_MASK;
                            12'h305: begin
                                r_mtvec[MXLEN-1:2] <= w_new[MXLEN-1:2];
                                if (w_new[1] == 1'b0) r_mtvec[1:0] <= w_new[1:0];
                            end
                            12'h340: r_mscratch <= w_new;
                            12'h341: r_mepc     <= {w_new[MXLEN-1:2], 2'b00};
                            12'h342: r_mcause   <= w_new;
                            12'h343: r_mtval    <= w_new;
                            default: ;
                        endcase
                    end
                end
                ST_TRAP_SAVE: begin
                    r_mepc         <= {r_trap_pc[MXLEN-1:2], 2'b00};
                    r_mcause       <= {r_trap_irq, {(MXLEN-6){1'b0}}, r_trap_code};
                    r_mtval        <= r_trap_tval;
                    r_mstatus_mpie <= r_mstatus_mie;
                    r_mstatus_mie  <= 1'b0;
                    r_redirect     <= 1'b1;
                    r_redirect_pc  <= w_trap_target;
                    r_state        <= ST_TRAP_REDIRECT;
                end
                ST_TRAP_REDIRECT: r_state <= ST_IDLE;
                ST_MRET_REDIRECT: r_state <= ST_IDLE;
                default:          r_state <= ST_IDLE;
            endcase
        end
    end

    // Registered read response and the per-cycle mip sample.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_rvalid  <= 1'b0;
            r_illegal <= 1'b0;
            r_rdata   <= '0;
            r_mip     <= '0;
        end else begin
            r_rvalid  <= w_accept;
            r_illegal <= w_accept && w_illegal;
            r_rdata   <= (w_accept && !w_illegal) ? w_old : '0;
            r_mip     <= w_mip_next;
        end
    end

    assign csr_read_data_o       = r_rdata;
    assign csr_read_data_valid_o = r_rvalid;
    assign csr_illegal_o         = r_illegal;
    assign busy_o                = !w_idle;
    assign redirect_o            = r_redirect;
    assign redirect_pc_o         = r_redirect_pc;
    assign dbg_state_o           = r_state;

endmodule

// File: tb/tb_machine_trap_unit.sv
// Bench for machine_trap_unit: CSR ops, illegal accesses, exception and
// vectored interrupt entry, MRET, request collision and reset mid-trap.
module tb_machine_trap_unit;

    localparam int XLEN = 32;
    localparam int NLOC = 4;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            csr_valid = 1'b0;
    logic [11:0]     csr_addr = '0;
    logic [1:0]      csr_op = '0;
    logic [XLEN-1:0] csr_wdata = '0;
    logic            csr_ready;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_rvalid;
    logic            csr_illegal;
    logic            exc = 1'b0;
    logic [4:0]      exc_cause = '0;
    logic [XLEN-1:0] exc_tval = '0;
    logic [XLEN-1:0] commit_pc = '0;
    logic            mret = 1'b0;
    logic [3+NLOC-1:0] irq = '0;
    logic            busy;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    int redir_pulses = 0;
    logic [XLEN:0] exp_q[$];
    logic [XLEN:0] mon_e;

    machine_trap_unit dut (
        .clock_i               (clk),
        .reset_i               (rst),
        .csr_valid_i           (csr_valid),
        .csr_address_i         (csr_addr),
        .csr_op_i              (csr_op),
        .csr_write_data_i      (csr_wdata),
        .csr_ready_o           (csr_ready),
        .csr_read_data_o       (csr_rdata),
        .csr_read_data_valid_o (csr_rvalid),
        .csr_illegal_o         (csr_illegal),
        .exception_i           (exc),
        .exception_cause_i     (exc_cause),
        .exception_tval_i      (exc_tval),
        .commit_pc_i           (commit_pc),
        .mret_i                (mret),
        .irq_i                 (irq),
        .busy_o                (busy),
        .redirect_o            (redirect),
        .redirect_pc_o         (redirect_pc),
        .dbg_state_o           (dbg_state)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Response scoreboard and redirect pulse counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (csr_rvalid) begin
            if (exp_q.size() == 0) begin
                check_val("rsp_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("rsp_data", csr_rdata, mon_e[XLEN-1:0]);
                check_val("rsp_illegal", csr_illegal, mon_e[XLEN]);
            end
        end
        if (redirect) redir_pulses++;
    end

    // Issue one CSR request and queue its expected response on acceptance.
    task automatic csr_access(input logic [1:0] op, input logic [11:0] addr,
                              input logic [XLEN-1:0] wd, input logic [XLEN-1:0] exp_d,
                              input logic exp_ill);
        int budget;
        budget = 0;
        @(negedge clk);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        #1;
        while (!csr_ready && budget < 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!csr_ready) check_val("csr_ready_timeout", 0, 1);
        else exp_q.push_back({exp_ill, exp_d});
        @(posedge clk);
        #1;
        csr_valid = 1'b0;
    endtask

    task automatic drive_exception(input logic [4:0] cause, input logic [XLEN-1:0] pc,
                                   input logic [XLEN-1:0] tval);
        @(negedge clk);
        exc       = 1'b1;
        exc_cause = cause;
        commit_pc = pc;
        exc_tval  = tval;
    endtask

    initial begin
        int p0;
        int budget;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_redirect", redirect, 0);
        check_val("rst_rvalid", csr_rvalid, 0);
        check_val("rst_ready", csr_ready, 0);
        check_val("rst_state", dbg_state, 0);
        rst = 1'b0;
        csr_access(OP_READ, 12'h300, 0, 32'h0000_1800, 0);
        csr_access(OP_READ, 12'hF14, 0, 32'h0, 0);
        csr_access(OP_READ, 12'h305, 0, 32'h0, 0);

        // Basic WRITE / SET / CLEAR
        csr_access(OP_WRITE, 12'h340, 32'hDEAD_BEEF, 32'h0, 0);
        csr_access(OP_SET,   12'h340, 32'h0000_00F0, 32'hDEAD_BEEF, 0);
        csr_access(OP_CLEAR, 12'h340, 32'h0000_000F, 32'hDEAD_BEFF, 0);
        csr_access(OP_READ,  12'h340, 0, 32'hDEAD_BEF0, 0);

        // Illegal accesses and read-only behaviour
        csr_access(OP_WRITE, 12'h301, 32'h0, 32'h0, 1);
        csr_access(OP_READ,  12'h301, 0, 32'h4000_1104, 0);
        csr_access(OP_READ,  12'h7C0, 0, 32'h0, 1);
        csr_access(OP_SET,   12'h344, 32'h0, 32'h0, 0);
        csr_access(OP_SET,   12'hF14, 32'h1, 32'h0, 1);

        // WARL fields
        csr_access(OP_WRITE, 12'h305, 32'h0000_0103, 32'h0, 0);
        csr_access(OP_READ,  12'h305, 0, 32'h0000_0100, 0);
        csr_access(OP_WRITE, 12'h341, 32'h0000_0087, 32'h0, 0);
        csr_access(OP_READ,  12'h341, 0, 32'h0000_0084, 0);
        csr_access(OP_WRITE, 12'h304, 32'hFFFF_FFFF, 32'h0, 0);
        csr_access(OP_WRITE, 12'h304, 32'h0, 32'h000F_0888, 0);
        csr_access(OP_WRITE, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 0);
        csr_access(OP_WRITE, 12'h300, 32'h0000_0008, 32'h0000_1888, 0);
        csr_access(OP_READ,  12'h300, 0, 32'h0000_1808, 0);

        // Exception entry
        drive_exception(5'd2, 32'h80, 32'h13);
        #1;
        check_val("exc_ready_low", csr_ready, 0);
        @(posedge clk); #1;
        exc = 1'b0;
        check_val("exc_n1_busy", busy, 1);
        check_val("exc_n1_redirect", redirect, 0);
        @(posedge clk); #1;
        check_val("exc_n2_redirect", redirect, 1);
        check_val("exc_n2_pc", redirect_pc, 32'h100);
        @(posedge clk); #1;
        check_val("exc_n3_idle", busy, 0);
        check_val("exc_n3_redirect", redirect, 0);
        csr_access(OP_READ, 12'h341, 0, 32'h80, 0);
        csr_access(OP_READ, 12'h342, 0, 32'h2, 0);
        csr_access(OP_READ, 12'h343, 0, 32'h13, 0);
        csr_access(OP_READ, 12'h300, 0, 32'h0000_1880, 0);

        // MRET
        @(negedge clk);
        mret = 1'b1;
        @(posedge clk); #1;
        mret = 1'b0;
        check_val("mret_redirect", redirect, 1);
        check_val("mret_pc", redirect_pc, 32'h80);
        check_val("mret_state", dbg_state, 3);
        @(posedge clk); #1;
        check_val("mret_done", busy, 0);
        csr_access(OP_READ, 12'h300, 0, 32'h0000_1888, 0);

        // Vectored interrupt, MTIP and MEIP together
        csr_access(OP_WRITE, 12'h305, 32'h0000_0201, 32'h100, 0);
        csr_access(OP_SET,   12'h304, 32'h0000_0880, 32'h0, 0);
        @(negedge clk);
        commit_pc = 32'h400;
        irq = 7'b000_0110;
        budget = 0;
        while (!redirect && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check_val("irq_redirect_seen", redirect, 1);
        check_val("irq_redirect_pc", redirect_pc, 32'h22C);
        irq = '0;
        repeat (2) @(negedge clk);
        check_val("irq_idle", busy, 0);
        csr_access(OP_READ, 12'h342, 0, 32'h8000_000B, 0);
        csr_access(OP_READ, 12'h341, 0, 32'h400, 0);
        csr_access(OP_READ, 12'h343, 0, 32'h0, 0);
        csr_access(OP_READ, 12'h300, 0, 32'h0000_1880, 0);

        // Exception colliding with a CSR write
        drive_exception(5'd5, 32'h90, 32'h7);
        csr_valid = 1'b1;
        csr_op    = OP_WRITE;
        csr_addr  = 12'h340;
        csr_wdata = 32'h1234_5678;
        #1;
        check_val("col_ready_low", csr_ready, 0);
        @(posedge clk); #1;
        exc       = 1'b0;
        csr_valid = 1'b0;
        check_val("col_state_save", dbg_state, 1);
        @(posedge clk); #1;
        check_val("col_redirect", redirect, 1);
        check_val("col_pc", redirect_pc, 32'h200);
        csr_access(OP_READ, 12'h340, 0, 32'hDEAD_BEF0, 0);
        csr_access(OP_READ, 12'h342, 0, 32'h5, 0);
        csr_access(OP_READ, 12'h341, 0, 32'h90, 0);

        // Reset while in TRAP_SAVE
        drive_exception(5'd1, 32'h44, 32'h0);
        @(posedge clk); #1;
        exc = 1'b0;
        check_val("rmt_in_save", dbg_state, 1);
        p0 = redir_pulses;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rmt_state_idle", dbg_state, 0);
        check_val("rmt_busy", busy, 0);
        check_val("rmt_redirect", redirect, 0);
        repeat (3) @(negedge clk);
        check_val("rmt_no_pulse", redir_pulses, p0);
        csr_access(OP_READ, 12'h341, 0, 32'h0, 0);
        csr_access(OP_READ, 12'h305, 0, 32'h0, 0);
        csr_access(OP_READ, 12'h300, 0, 32'h0000_1800, 0);
        csr_access(OP_READ, 12'h342, 0, 32'h0, 0);

        repeat (2) @(negedge clk);
        check_val("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
